router_read_arbiter: RTL and testbench

Read-side scheduler for the 1x3 router. Watches the three output FIFOs' valid flags, grants one port at a time in round-robin order, drives that port's read enable, and serialises whole packets onto one downstream byte channel. It marks start and end of packet, checks packet parity, and recovers from a FIFO that stalls mid-packet. Sits between the router top's output ports and a single consumer.

---
 rtl/router_read_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_router_read_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_read_arbiter.sv
// Read-side scheduler for the 1x3 router: round-robin packet arbitration over three
// output FIFOs, serialised onto one byte stream with sop/eop, parity check and stall abort.
module router_read_arbiter #(
    parameter int unsigned STALL_LIMIT = 32
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic [1:0] out_port,
    output logic       parity_err,
    output logic       pkt_abort
);

    localparam int unsigned REM_W   = 7;
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       perr;
        logic [1:0] port;
    } beat_t;

    state_t             state;
    logic [1:0]         ptr;
    logic [1:0]         gnt;
    logic [REM_W-1:0]   remaining;
    logic [STALL_W-1:0] stall_cnt;
    logic               run;

    // One read in flight: its byte lands on data_out_x the cycle after read_enb
    logic               rd_pend;
    logic               pend_sop;
    logic               pend_eop;
    logic [1:0]         pend_port;
    logic [7:0]         xor_acc;

    beat_t              mem [2];
    logic               wr_idx;
    logic               rd_idx;
    logic [1:0]         count;

    logic [2:0]         vld;
    logic [7:0]         land_data;
    beat_t              land;
    beat_t              cur;
    logic               arb_found;
    logic [1:0]         arb_gnt;
    logic [1:0]         cand;
    logic               space;
    logic               rd_fire;
    logic [1:0]         rd_port;
    logic               rd_sop;
    logic               rd_eop;
    logic               abort_c;
    logic               land_wr;
    logic               pop_buf;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign vld = {vld_out_2, vld_out_1, vld_out_0};

    always_comb begin
        land_data = 8'h00;
        case (pend_port)
            2'd0:    land_data = data_out_0;
            2'd1:    land_data = data_out_1;
            2'd2:    land_data = data_out_2;
            default: land_data = 8'h00;
        endcase
    end

    always_comb begin
        land.data = land_data;
        land.sop  = pend_sop;
        land.eop  = pend_eop;
        land.perr = pend_eop && (xor_acc != land_data);
        land.port = pend_port;
    end

    // First requester at or after the round-robin pointer
    always_comb begin
        arb_found = 1'b0;
        arb_gnt   = 2'd0;
        cand      = ptr;
        for (int i = 0; i < 3; i++) begin
            if (!arb_found && vld[cand]) begin
                arb_found = 1'b1;
                arb_gnt   = cand;
            end
            cand = nxt(cand);
        end
    end

    assign space = (count + {1'b0, rd_pend}) < 2'd2;

    always_comb begin
        rd_fire = 1'b0;
        rd_port = gnt;
        rd_sop  = 1'b0;
        rd_eop  = 1'b0;
        case (state)
            IDLE: begin
                if (run && arb_found && space) begin
                    rd_fire = 1'b1;
                    rd_port = arb_gnt;
                    rd_sop  = 1'b1;
                end
            end
            BODY: begin
                if (vld[gnt] && (remaining != '0) && space) begin
                    rd_fire = 1'b1;
                    rd_eop  = (remaining == REM_W'(1));
                end
            end
            default: ;
        endcase
    end

    assign read_enb_0 = rd_fire && (rd_port == 2'd0);
    assign read_enb_1 = rd_fire && (rd_port == 2'd1);
    assign read_enb_2 = rd_fire && (rd_port == 2'd2);

    assign abort_c = (state == BODY) && !vld[gnt] &&
                     (stall_cnt == STALL_W'(STALL_LIMIT - 1));

    // Landing byte bypasses the buffer when it is empty and the consumer takes it
    assign land_wr = rd_pend && !((count == 2'd0) && out_ready);
    assign pop_buf = (count != 2'd0) && out_ready;

    always_comb begin
        cur = '0;
        if (count != 2'd0) begin
            cur = mem[rd_idx];
        end else if (rd_pend) begin
            cur = land;
        end
    end

    assign out_valid  = (count != 2'd0) || rd_pend;
    assign out_data   = cur.data;
    assign out_sop    = cur.sop;
    assign out_eop    = cur.eop;
    assign out_port   = cur.port;
    assign parity_err = cur.perr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt       <= 2'd0;
            remaining <= '0;
            stall_cnt <= '0;
            run       <= 1'b0;
            rd_pend   <= 1'b0;
            pend_sop  <= 1'b0;
            pend_eop  <= 1'b0;
            pend_port <= 2'd0;
            xor_acc   <= 8'h00;
            wr_idx    <= 1'b0;
            rd_idx    <= 1'b0;
            count     <= 2'd0;
            pkt_abort <= 1'b0;
        end else begin
            run       <= 1'b1;
            pkt_abort <= 1'b0;
            rd_pend   <= rd_fire;
            if (rd_fire) begin
                pend_sop  <= rd_sop;
                pend_eop  <= rd_eop;
                pend_port <= rd_port;
            end
            if (rd_pend) begin
                if (pend_sop) begin
                    xor_acc <= land_data;
                end else if (!pend_eop) begin
                    xor_acc <= xor_acc ^ land_data;
                end
            end
            count <= count + 2'(land_wr) - 2'(pop_buf);
            if (land_wr) wr_idx <= ~wr_idx;
            if (pop_buf) rd_idx <= ~rd_idx;

            case (state)
                IDLE: begin
                    if (rd_fire) begin
                        gnt   <= arb_gnt;
                        state <= HDR;
                    end
                end
                HDR: begin
                    remaining <= REM_W'(land_data[7:2]) + REM_W'(1);
                    stall_cnt <= '0;
                    state     <= BODY;
                end
                BODY: begin
                    if (rd_fire) begin
                        remaining <= remaining - REM_W'(1);
                        stall_cnt <= '0;
                        if (remaining == REM_W'(1)) begin
                            ptr   <= nxt(gnt);
                            state <= IDLE;
                        end
                    end else if (abort_c) begin
                        pkt_abort <= 1'b1;
                        remaining <= '0;
                        stall_cnt <= '0;
                        ptr       <= nxt(gnt);
                        state     <= IDLE;
                    end else if (!vld[gnt]) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer payload needs no reset: count gates every read of it
    always_ff @(posedge clock) begin
        if (land_wr) mem[wr_idx] <= land;
    end

endmodule

// File: tb/tb_router_read_arbiter.sv
// Scoreboard bench for router_read_arbiter: three FIFO models with registered read data,
// per-port expected-beat queues and an expected grant-order queue.
module tb_router_read_arbiter;

    localparam int unsigned STALL_LIMIT = 32;

    logic       clock = 1'b0;
    logic       resetn;
    logic       out_ready;
    logic       flush;
    logic       bp_mode;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop, out_eop;
    logic [1:0] out_port;
    logic       parity_err, pkt_abort;

    logic [7:0] fmem [3][1024];
    logic [9:0] wp [3] = '{default: 10'd0};
    logic [9:0] rp [3] = '{default: 10'd0};
    logic [7:0] dq [3] = '{default: 8'd0};
    logic [2:0] rd_vec;
    logic [2:0] vld_vec;

    int n_chk = 0;
    int n_fail = 0;
    int n_beats = 0;
    int n_abort = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int occ = 0;
    int cur_port = 0;
    int exp_q0[$];
    int exp_q1[$];
    int exp_q2[$];
    int exp_sop[$];

    always #5 clock = ~clock;

    router_read_arbiter #(.STALL_LIMIT(STALL_LIMIT)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .vld_out_0  (vld_out_0),
        .vld_out_1  (vld_out_1),
        .vld_out_2  (vld_out_2),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .read_enb_0 (read_enb_0),
        .read_enb_1 (read_enb_1),
        .read_enb_2 (read_enb_2),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_port   (out_port),
        .parity_err (parity_err),
        .pkt_abort  (pkt_abort)
    );

    assign rd_vec     = {read_enb_2, read_enb_1, read_enb_0};
    assign vld_out_0  = (wp[0] != rp[0]);
    assign vld_out_1  = (wp[1] != rp[1]);
    assign vld_out_2  = (wp[2] != rp[2]);
    assign vld_vec    = {vld_out_2, vld_out_1, vld_out_0};
    assign data_out_0 = dq[0];
    assign data_out_1 = dq[1];
    assign data_out_2 = dq[2];

    // FIFO models: read data registered on the read edge
    always @(posedge clock) begin
        for (int p = 0; p < 3; p++) begin
            if (flush) begin
                rp[p] <= wp[p];
            end else if (rd_vec[p]) begin
                dq[p] <= fmem[p][rp[p]];
                rp[p] <= rp[p] + 10'd1;
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int q_size(input int p);
        case (p)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic int q_front(input int p);
        case (p)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    task automatic q_push(input int p, input int v);
        case (p)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic q_pop(input int p);
        case (p)
            0:       void'(exp_q0.pop_front());
            1:       void'(exp_q1.pop_front());
            default: void'(exp_q2.pop_front());
        endcase
    endtask

    function automatic int outs_vec();
        return 32'({read_enb_2, read_enb_1, read_enb_0, out_valid, out_sop, out_eop,
                    parity_err, pkt_abort, out_port, out_data});
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Load a packet (or its first nsup bytes) into a FIFO and push the expected beats
    task automatic load_pkt(input int port, input int len, input int nsup,
                            input bit corrupt, input bit fixed);
        logic [7:0] b[$];
        logic [7:0] x;
        logic [7:0] pb;
        int n;
        b.push_back({6'(len), 2'(port)});
        x = b[0];
        for (int i = 0; i < len; i++) begin
            pb = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            b.push_back(pb);
            x = x ^ pb;
        end
        b.push_back(x ^ {7'd0, corrupt});
        n = (nsup < 0) ? b.size() : nsup;
        for (int i = 0; i < n; i++) begin
            fmem[port][wp[port]] = b[i];
            wp[port] = wp[port] + 10'd1;
            q_push(port, 32'({b[i], (i == 0), (i == len + 1), (corrupt && (i == len + 1))}));
        end
        exp_sop.push_back(port);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0; i++)
            step();
        chk("drain", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
        repeat (3) step();
    endtask

    task automatic wait_beats(input int target, input int budget);
        for (int i = 0; i < budget && n_beats < target; i++) step();
        chk("beats_reached", 32'(n_beats >= target), 1);
    endtask

    task automatic ready_loop();
        int ph = 0;
        forever begin
            @(posedge clock);
            #1;
            if (bp_mode) begin
                out_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
                ph = 0;
            end
        end
    endtask

    task automatic monitor_loop();
        int p;
        forever begin
            @(negedge clock);
            cyc++;
            if (!resetn) begin
                occ = 0;
                continue;
            end
            if (pkt_abort) begin
                n_abort++;
                chk("abort_gap", cyc - last_rd_cyc, int'(STALL_LIMIT) + 1);
            end
            if (rd_vec != 3'b000) begin
                chk("rd_onehot", $countones(rd_vec), 1);
                chk("rd_when_vld", 32'(rd_vec & ~vld_vec), 0);
                last_rd_cyc = cyc;
            end
            if (out_valid) begin
                p = int'(out_port);
                chk("beat_pending", 32'(q_size(p) != 0), 1);
                if (q_size(p) != 0) begin
                    chk("beat", 32'({out_data, out_sop, out_eop, parity_err}), q_front(p));
                    if (out_ready) begin
                        q_pop(p);
                        n_beats++;
                        if (out_sop) begin
                            chk("sop_pending", 32'(exp_sop.size() != 0), 1);
                            if (exp_sop.size() != 0) chk("grant_order", p, exp_sop.pop_front());
                            cur_port = p;
                        end else begin
                            chk("contig", p, cur_port);
                        end
                    end
                end
            end
            occ = occ + ((rd_vec != 3'b000) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            chk("occupancy", 32'(occ <= 2), 1);
        end
    endtask

    initial begin
        int b0;
        int a0;
        resetn    = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        bp_mode   = 1'b0;
        fork
            monitor_loop();
            ready_loop();
        join_none

        // All three ports hold an L=2 packet at reset release
        load_pkt(0, 2, -1, 1'b0, 1'b0);
        load_pkt(1, 2, -1, 1'b0, 1'b0);
        load_pkt(2, 2, -1, 1'b0, 1'b0);
        repeat (3) step();
        chk("reset_outputs", outs_vec(), 0);
        resetn = 1'b1;
        wait_drain(100);

        b0 = n_beats;
        load_pkt(1, 3, -1, 1'b0, 1'b1);
        wait_drain(100);
        chk("single_pkt_beats", n_beats - b0, 5);

        // Back-pressure 1,0,0,1 during a long packet
        bp_mode = 1'b1;
        load_pkt(0, 10, -1, 1'b0, 1'b0);
        wait_drain(200);
        bp_mode = 1'b0;
        repeat (2) step();

        // Corrupted parity followed by a clean packet on the same port
        load_pkt(1, 4, -1, 1'b1, 1'b0);
        load_pkt(1, 3, -1, 1'b0, 1'b0);
        wait_drain(100);

        // Port 2 stalls after one payload byte; port 0 waits behind it
        a0 = n_abort;
        b0 = n_beats;
        load_pkt(2, 4, 2, 1'b0, 1'b0);
        repeat (5) step();
        load_pkt(0, 2, -1, 1'b0, 1'b0);
        wait_drain(300);
        chk("abort_count", n_abort - a0, 1);
        chk("abort_phase_beats", n_beats - b0, 6);

        // Reset in the middle of a packet body
        b0 = n_beats;
        load_pkt(0, 20, -1, 1'b0, 1'b0);
        wait_beats(b0 + 4, 100);
        #2;
        resetn = 1'b0;
        #1;
        chk("reset_mid_body", outs_vec(), 0);
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        exp_q0.delete();
        exp_sop.delete();
        step();
        chk("reset_held", outs_vec(), 0);
        resetn = 1'b1;
        load_pkt(1, 3, -1, 1'b0, 1'b0);
        load_pkt(2, 1, -1, 1'b0, 1'b0);
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
